// File: rtl/branch_resolver.sv
// Verifying end of the PC/BHT prediction loop: carries fetch-time prediction
// metadata through ID to EX, resolves it there and drives the PC unit's correction port.
module branch_resolver #(
  parameter int IM_ADDR_BIT = 10,
  parameter int CNT_W       = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   stall,
  input  logic                   if_valid,
  input  logic [IM_ADDR_BIT-1:0] if_pc,
  input  logic                   if_gussed,
  input  logic [IM_ADDR_BIT-1:0] if_pred_addr,
  input  logic                   ex_isbj,
  input  logic                   ex_taken,
  input  logic [IM_ADDR_BIT-1:0] ex_target,
  output logic                   succeed,
  output logic                   gone,
  output logic [IM_ADDR_BIT-1:0] g_addr,
  output logic [IM_ADDR_BIT-1:0] s_addr,
  output logic [IM_ADDR_BIT-1:0] pc_before_g,
  output logic                   isbj,
  output logic                   flush,
  output logic [CNT_W-1:0]       br_cnt,
  output logic [CNT_W-1:0]       miss_cnt
);

  typedef enum logic {NORMAL = 1'b0, RECOVER = 1'b1} state_t;

  state_t state_reg, state_next;

  logic                   id_v_reg, ex_v_reg;
  logic [IM_ADDR_BIT-1:0] id_pc_reg, ex_pc_reg;
  logic                   id_gussed_reg, ex_gussed_reg;
  logic [IM_ADDR_BIT-1:0] id_pred_reg, ex_pred_reg;
  logic [CNT_W-1:0]       br_cnt_reg, miss_cnt_reg;

  logic live;
  logic mispredict;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= NORMAL;
    end else if (en) begin
      state_reg <= state_next;
    end
  end

  // FSM next state: RECOVER is always a single-cycle blind spot
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      NORMAL:  state_next = mispredict ? RECOVER : NORMAL;
      RECOVER: state_next = NORMAL;
      default: state_next = NORMAL;
    endcase
  end

  // Resolution outputs; addresses are zeroed when EX is not live
  always_comb begin
    live        = ex_v_reg && (state_reg == NORMAL);
    mispredict  = 1'b0;
    succeed     = 1'b1;
    gone        = 1'b0;
    isbj        = 1'b0;
    g_addr      = '0;
    s_addr      = '0;
    pc_before_g = '0;
    if (live) begin
      if (ex_isbj) begin
        mispredict = (ex_taken != ex_gussed_reg) ||
                     (ex_taken && ex_gussed_reg && (ex_target != ex_pred_reg));
      end else begin
        mispredict = ex_gussed_reg;
      end
      succeed     = ~mispredict;
      gone        = ex_isbj & ex_taken;
      isbj        = ex_isbj;
      g_addr      = ex_target;
      s_addr      = ex_pc_reg + IM_ADDR_BIT'(1);
      pc_before_g = ex_pc_reg;
    end
  end

  assign flush = ~succeed;

  // ID/EX metadata pipeline; a mispredict overrides a concurrent stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_v_reg      <= 1'b0;
      id_pc_reg     <= '0;
      id_gussed_reg <= 1'b0;
      id_pred_reg   <= '0;
      ex_v_reg      <= 1'b0;
      ex_pc_reg     <= '0;
      ex_gussed_reg <= 1'b0;
      ex_pred_reg   <= '0;
    end else if (en) begin
      if (mispredict) begin
        id_v_reg <= 1'b0;
        ex_v_reg <= 1'b0;
      end else if (stall) begin
        ex_v_reg <= 1'b0;
      end else begin
        ex_v_reg      <= id_v_reg;
        ex_pc_reg     <= id_pc_reg;
        ex_gussed_reg <= id_gussed_reg;
        ex_pred_reg   <= id_pred_reg;
        id_v_reg      <= if_valid;
        id_pc_reg     <= if_pc;
        id_gussed_reg <= if_gussed;
        id_pred_reg   <= if_pred_addr;
      end
    end
  end

  // Saturating statistics
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_cnt_reg   <= '0;
      miss_cnt_reg <= '0;
    end else if (en && live) begin
      if (ex_isbj && (br_cnt_reg != '1)) begin
        br_cnt_reg <= br_cnt_reg + CNT_W'(1);
      end
      if (mispredict && (miss_cnt_reg != '1)) begin
        miss_cnt_reg <= miss_cnt_reg + CNT_W'(1);
      end
    end
  end

  assign br_cnt   = br_cnt_reg;
  assign miss_cnt = miss_cnt_reg;

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver: hand-computed expectations checked with
// immediate assertions along one linear stimulus sequence.
module tb_branch_resolver;

  logic        clk;
  logic        rst;
  logic        en;
  logic        stall;
  logic        if_valid;
  logic [9:0]  if_pc;
  logic        if_gussed;
  logic [9:0]  if_pred_addr;
  logic        ex_isbj;
  logic        ex_taken;
  logic [9:0]  ex_target;
  logic        succeed;
  logic        gone;
  logic [9:0]  g_addr;
  logic [9:0]  s_addr;
  logic [9:0]  pc_before_g;
  logic        isbj;
  logic        flush;
  logic [31:0] br_cnt;
  logic [31:0] miss_cnt;

  int total = 0;
  int bad   = 0;

  branch_resolver #(.IM_ADDR_BIT(10), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .en(en), .stall(stall),
    .if_valid(if_valid), .if_pc(if_pc), .if_gussed(if_gussed), .if_pred_addr(if_pred_addr),
    .ex_isbj(ex_isbj), .ex_taken(ex_taken), .ex_target(ex_target),
    .succeed(succeed), .gone(gone), .g_addr(g_addr), .s_addr(s_addr),
    .pc_before_g(pc_before_g), .isbj(isbj), .flush(flush),
    .br_cnt(br_cnt), .miss_cnt(miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_if(input logic v, input logic [9:0] pc, input logic g, input logic [9:0] pa);
    if_valid     = v;
    if_pc        = pc;
    if_gussed    = g;
    if_pred_addr = pa;
  endtask

  task automatic set_ex(input logic b, input logic t, input logic [9:0] tgt);
    ex_isbj   = b;
    ex_taken  = t;
    ex_target = tgt;
  endtask

  // Present one fetch, then let it ride two edges into EX with a quiet EX in between
  task automatic run_to_ex(input logic [9:0] pc, input logic g, input logic [9:0] pa);
    set_ex(1'b0, 1'b0, 10'h0);
    set_if(1'b1, pc, g, pa);
    tick();
    set_if(1'b0, 10'h0, 1'b0, 10'h0);
    tick();
  endtask

  initial begin
    rst   = 1'b1;
    en    = 1'b1;
    stall = 1'b0;
    set_if(1'b0, 10'h0, 1'b0, 10'h0);
    set_ex(1'b1, 1'b1, 10'h55);
    #2;
    chk("rst_succeed", 32'(succeed), 32'd1);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_gone", 32'(gone), 32'd0);
    chk("rst_isbj", 32'(isbj), 32'd0);
    chk("rst_g_addr", 32'(g_addr), 32'd0);
    chk("rst_s_addr", 32'(s_addr), 32'd0);
    chk("rst_pc_before_g", 32'(pc_before_g), 32'd0);
    chk("rst_br_cnt", br_cnt, 32'd0);
    chk("rst_miss_cnt", miss_cnt, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    set_ex(1'b0, 1'b0, 10'h0);

    // Sequential fetches 0..3, no branches
    for (int i = 0; i < 6; i++) begin
      set_if(i < 4, 10'(i), 1'b0, 10'(i + 1));
      #1;
      chk("seq_succeed", 32'(succeed), 32'd1);
      if (i >= 2) begin
        chk("seq_pc_before_g", 32'(pc_before_g), 32'(i - 2));
        chk("seq_s_addr", 32'(s_addr), 32'(i - 1));
      end
      tick();
    end
    chk("seq_br_cnt", br_cnt, 32'd0);
    chk("seq_miss_cnt", miss_cnt, 32'd0);

    // Not-predicted taken branch at pc 5, wrong-path pc 6 sits in ID
    set_if(1'b1, 10'd5, 1'b0, 10'd6);
    tick();
    set_if(1'b1, 10'd6, 1'b0, 10'd7);
    tick();
    set_if(1'b0, 10'h0, 1'b0, 10'h0);
    set_ex(1'b1, 1'b1, 10'h40);
    #1;
    chk("mp1_succeed", 32'(succeed), 32'd0);
    chk("mp1_flush", 32'(flush), 32'd1);
    chk("mp1_gone", 32'(gone), 32'd1);
    chk("mp1_g_addr", 32'(g_addr), 32'h40);
    chk("mp1_pc_before_g", 32'(pc_before_g), 32'd5);
    chk("mp1_s_addr", 32'(s_addr), 32'd6);
    chk("mp1_isbj", 32'(isbj), 32'd1);
    tick();
    set_if(1'b1, 10'h40, 1'b0, 10'h41);
    #1;
    chk("rec_succeed", 32'(succeed), 32'd1);
    chk("rec_isbj", 32'(isbj), 32'd0);
    chk("rec_state", 32'(dut.state_reg), 32'd1);
    chk("rec_miss_cnt", miss_cnt, 32'd1);
    chk("rec_br_cnt", br_cnt, 32'd1);
    tick();
    set_if(1'b0, 10'h0, 1'b0, 10'h0);
    set_ex(1'b0, 1'b0, 10'h0);
    tick();
    #1;
    chk("redir_succeed", 32'(succeed), 32'd1);
    chk("redir_pc_before_g", 32'(pc_before_g), 32'h40);
    tick();

    // Predicted taken, wrong target
    run_to_ex(10'd8, 1'b1, 10'h20);
    set_ex(1'b1, 1'b1, 10'h24);
    #1;
    chk("tgt_succeed", 32'(succeed), 32'd0);
    chk("tgt_g_addr", 32'(g_addr), 32'h24);
    tick();
    chk("tgt_br_cnt", br_cnt, 32'd2);
    chk("tgt_miss_cnt", miss_cnt, 32'd2);

    // Predicted taken, correct target
    run_to_ex(10'd8, 1'b1, 10'h20);
    set_ex(1'b1, 1'b1, 10'h20);
    #1;
    chk("hit_succeed", 32'(succeed), 32'd1);
    chk("hit_isbj", 32'(isbj), 32'd1);
    tick();
    chk("hit_br_cnt", br_cnt, 32'd3);
    chk("hit_miss_cnt", miss_cnt, 32'd2);

    // Predicted taken, actually not taken
    run_to_ex(10'd9, 1'b1, 10'h30);
    set_ex(1'b1, 1'b0, 10'h0);
    #1;
    chk("nt_succeed", 32'(succeed), 32'd0);
    chk("nt_gone", 32'(gone), 32'd0);
    chk("nt_s_addr", 32'(s_addr), 32'd10);
    tick();
    chk("nt_miss_cnt", miss_cnt, 32'd3);

    // Predicted not taken, actually not taken
    run_to_ex(10'h10, 1'b0, 10'h11);
    set_ex(1'b1, 1'b0, 10'h0);
    #1;
    chk("nn_succeed", 32'(succeed), 32'd1);
    tick();
    chk("nn_br_cnt", br_cnt, 32'd5);
    chk("nn_miss_cnt", miss_cnt, 32'd3);

    // BHT alias on a non-branch at the top of the address space
    run_to_ex(10'h3FF, 1'b1, 10'h10);
    set_ex(1'b0, 1'b0, 10'h0);
    #1;
    chk("alias_succeed", 32'(succeed), 32'd0);
    chk("alias_gone", 32'(gone), 32'd0);
    chk("alias_s_addr", 32'(s_addr), 32'h000);
    chk("alias_pc_before_g", 32'(pc_before_g), 32'h3FF);
    chk("alias_isbj", 32'(isbj), 32'd0);
    tick();
    chk("alias_br_cnt", br_cnt, 32'd5);
    chk("alias_miss_cnt", miss_cnt, 32'd4);

    // Two-cycle stall with a branch held in ID
    set_if(1'b1, 10'h50, 1'b1, 10'h60);
    tick();
    stall = 1'b1;
    set_if(1'b1, 10'h51, 1'b0, 10'h52);
    set_ex(1'b1, 1'b1, 10'h60);
    #1;
    chk("stall1_isbj", 32'(isbj), 32'd0);
    chk("stall1_succeed", 32'(succeed), 32'd1);
    tick();
    chk("stall2_isbj", 32'(isbj), 32'd0);
    chk("stall2_succeed", 32'(succeed), 32'd1);
    tick();
    stall = 1'b0;
    set_if(1'b0, 10'h0, 1'b0, 10'h0);
    #1;
    chk("stall3_isbj", 32'(isbj), 32'd0);
    tick();
    chk("stall_res_succeed", 32'(succeed), 32'd1);
    chk("stall_res_isbj", 32'(isbj), 32'd1);
    chk("stall_res_pc", 32'(pc_before_g), 32'h50);
    tick();
    chk("stall_br_cnt", br_cnt, 32'd6);
    chk("stall_miss_cnt", miss_cnt, 32'd4);

    // Stall and mispredict together: squash wins
    set_ex(1'b0, 1'b0, 10'h0);
    set_if(1'b1, 10'h70, 1'b0, 10'h71);
    tick();
    set_if(1'b1, 10'h71, 1'b0, 10'h72);
    tick();
    stall = 1'b1;
    set_if(1'b0, 10'h0, 1'b0, 10'h0);
    set_ex(1'b1, 1'b1, 10'h80);
    #1;
    chk("sm_succeed", 32'(succeed), 32'd0);
    tick();
    stall = 1'b0;
    set_ex(1'b1, 1'b0, 10'h0);
    #1;
    chk("sm_rec_isbj", 32'(isbj), 32'd0);
    chk("sm_br_cnt", br_cnt, 32'd7);
    chk("sm_miss_cnt", miss_cnt, 32'd5);
    tick();
    chk("sm_after_isbj", 32'(isbj), 32'd0);
    chk("sm_after_succeed", 32'(succeed), 32'd1);

    // en low holds everything, outputs still show EX
    run_to_ex(10'h20, 1'b1, 10'h21);
    set_ex(1'b0, 1'b0, 10'h0);
    en = 1'b0;
    #1;
    chk("en_succeed", 32'(succeed), 32'd0);
    tick();
    chk("en_hold_succeed", 32'(succeed), 32'd0);
    chk("en_hold_pc", 32'(pc_before_g), 32'h20);
    chk("en_hold_miss_cnt", miss_cnt, 32'd5);
    en = 1'b1;
    tick();
    chk("en_miss_cnt", miss_cnt, 32'd6);

    // Counter saturation
    run_to_ex(10'h90, 1'b0, 10'h91);
    set_ex(1'b1, 1'b1, 10'hA0);
    #1;
    chk("sat_succeed", 32'(succeed), 32'd0);
    force dut.br_cnt_reg = 32'hFFFF_FFFF;
    force dut.miss_cnt_reg = 32'hFFFF_FFFF;
    #1;
    release dut.br_cnt_reg;
    release dut.miss_cnt_reg;
    tick();
    chk("sat_br_cnt", br_cnt, 32'hFFFF_FFFF);
    chk("sat_miss_cnt", miss_cnt, 32'hFFFF_FFFF);

    // Asynchronous reset mid-stream
    run_to_ex(10'h100, 1'b1, 10'h11);
    set_ex(1'b1, 1'b1, 10'h22);
    #1;
    chk("pre_rst_succeed", 32'(succeed), 32'd0);
    rst = 1'b1;
    #1;
    chk("mid_rst_succeed", 32'(succeed), 32'd1);
    chk("mid_rst_flush", 32'(flush), 32'd0);
    chk("mid_rst_gone", 32'(gone), 32'd0);
    chk("mid_rst_isbj", 32'(isbj), 32'd0);
    chk("mid_rst_g_addr", 32'(g_addr), 32'd0);
    chk("mid_rst_s_addr", 32'(s_addr), 32'd0);
    chk("mid_rst_br_cnt", br_cnt, 32'd0);
    chk("mid_rst_miss_cnt", miss_cnt, 32'd0);
    tick();
    rst = 1'b0;

    // First live entry two enabled edges after release
    set_ex(1'b0, 1'b0, 10'h0);
    set_if(1'b1, 10'h33, 1'b1, 10'h34);
    tick();
    set_if(1'b0, 10'h0, 1'b0, 10'h0);
    #1;
    chk("post_rst_one_edge", 32'(succeed), 32'd1);
    tick();
    chk("post_rst_succeed", 32'(succeed), 32'd0);
    chk("post_rst_pc", 32'(pc_before_g), 32'h33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_resolver.md
Name: branch_resolver

Overview:
- Carries each fetched PC's prediction metadata (BHT hit, guessed address) from IF through ID to EX.
- In EX it compares the prediction with the actual branch/jump outcome and drives the PC unit's correction interface (succeed, gone, g_addr, s_addr, pc_before_g, isbj).
- On a mispredict it squashes younger entries and keeps saturating branch and mispredict statistics.
- It is the verifying end of the PC/BHT prediction loop.

Parameters:
- IM_ADDR_BIT, 10, instruction word-address width; sequential PC is pc+1.
- CNT_W, 32, width of the statistics counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  global enable; when low, all state holds.
- stall  in  1  load-use stall: ID entry holds, a bubble enters EX.
- if_valid  in  1  the IF slot holds a real fetch.
- if_pc  in  IM_ADDR_BIT  PC of the fetched instruction.
- if_gussed  in  1  BHT hit (prediction taken) for if_pc.
- if_pred_addr  in  IM_ADDR_BIT  address the PC unit fetched next.
- ex_isbj  in  1  the EX instruction is a branch or jump.
- ex_taken  in  1  actual outcome; meaningful only when ex_isbj=1.
- ex_target  in  IM_ADDR_BIT  actual target; meaningful only when ex_taken=1.
- succeed  out  1  0 = redirect the PC this cycle.
- gone  out  1  actual taken flag; selects g_addr or s_addr.
- g_addr  out  IM_ADDR_BIT  actual taken target.
- s_addr  out  IM_ADDR_BIT  EX pc + 1, truncated to IM_ADDR_BIT (wraps).
- pc_before_g  out  IM_ADDR_BIT  PC of the EX instruction, for the BHT update.
- isbj  out  1  BHT write enable.
- flush  out  1  squash IF/ID; equals ~succeed.
- br_cnt  out  CNT_W  resolved branches/jumps.
- miss_cnt  out  CNT_W  mispredicts.

Behaviour:
- State:
  - ID entry: valid, pc, gussed, pred_addr.
  - EX entry: the same fields.
  - FSM {NORMAL, RECOVER}.
  - Two counters.
- Reset (async, rst=1):
  - Entries invalid, FSM=NORMAL, counters=0.
  - Outputs: succeed=1, gone=0, isbj=0, flush=0, all addresses 0.
- Outputs are combinational from the EX entry and ex_* only; no combinational path from if_* to any output.
- An EX entry is live when ex_v=1 and FSM=NORMAL.
- mispredict (only when the EX entry is live):
  - ex_isbj & (ex_taken != gussed); or
  - ex_isbj & ex_taken & gussed & (ex_target != pred_addr); or
  - ~ex_isbj & gussed (BHT alias on a non-branch).
- succeed = ~mispredict. gone = ex_isbj & ex_taken. g_addr = ex_target. isbj = live & ex_isbj.
- When the EX entry is not live: succeed=1, isbj=0, gone=0.
- Pipeline advance (en=1):
  - mispredict: ID and EX entries become invalid; FSM goes to RECOVER.
  - else if stall: ID entry holds, EX entry becomes invalid (bubble).
  - else: EX <= ID, ID <= IF inputs (valid = if_valid).
- RECOVER lasts exactly one cycle, then NORMAL.
  - During RECOVER, EX is ignored even if it is valid.
  - Pipeline advance continues normally, so the redirected fetch enters ID.
- Counters (en=1, EX entry live):
  - br_cnt += 1 when ex_isbj; miss_cnt += 1 on mispredict.
  - Both saturate at all-ones, never wrap.
- Simultaneous stall and mispredict: mispredict wins; the stall is ignored that cycle.
- en=0: no state change. Outputs still reflect the current EX entry, so the PC unit's own en gating decides whether to act.
- rst asserted mid-operation: immediate clear, including the counters; the first live entry arrives two enabled edges after reset release.

Test Plan:
- Reset then 4 sequential fetches (pc 0..3, gussed=0, no branches) -> succeed=1 every cycle, br_cnt=0, miss_cnt=0.
- Fetch pc=5, gussed=0; in EX ex_isbj=1, ex_taken=1, ex_target=0x40 -> succeed=0, gone=1, g_addr=0x40, pc_before_g=5, s_addr=6, isbj=1; next cycle the EX entry is squashed, FSM=RECOVER, succeed=1; miss_cnt=1.
- Fetch pc=8, gussed=1, pred_addr=0x20; actual taken to 0x24 -> succeed=0, g_addr=0x24. A second case with actual target 0x20 -> succeed=1, br_cnt increments, miss_cnt unchanged.
- Fetch pc=0x3FF (IM_ADDR_BIT=10), gussed=1, non-branch -> succeed=0, gone=0, s_addr=0x000.
- stall high for 2 cycles with a branch in ID -> EX receives bubbles (isbj=0), the ID entry is preserved and resolves correctly after stall drops. stall and mispredict in the same cycle -> squash.
- Preload miss_cnt and br_cnt to all-ones (force), then another mispredict -> both counters stay all-ones. Assert rst mid-stream -> all outputs at reset values within the same cycle.
